lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit that sits directly upstream of the word-wide data RAM (`ram`: combinational read, write on clk edge when `we` is high).
- Turns CPU byte, halfword and word accesses into word accesses. Covers byte-lane merge, sign/zero extension and misaligned accesses that span two words.
- Sub-word and spanning stores run as read-modify-write sequences under an FSM. The CPU stalls while `req_ready` is low.

Parameters:
- ADDRESS_LENGTH, 32, width of the CPU byte address and of the RAM word index `mem_a`.
- MEM_WORDS, 10000, number of RAM words. Any word index >= MEM_WORDS is an error.
- ALLOW_MISALIGNED, 1, when 1 spanning accesses are split into two words; when 0 they return an error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: LB000, LH001, LW010, LBU100, LHU101; SB000, SH001, SW010.
- req_addr  in  ADDRESS_LENGTH  byte address.
- req_wdata  in  32  store data, taken from the low bytes.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  error flag (illegal funct3, out of range, misaligned with ALLOW_MISALIGNED=0); valid with resp_valid.
- mem_a  out  ADDRESS_LENGTH  RAM word index.
- mem_we  out  1  RAM write enable.
- mem_wd  out  32  RAM write data.
- mem_rd  in  32  RAM read data, combinational from mem_a.

Behaviour:
- Reset:
  - Asynchronous; while rst is high: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, all captured registers cleared.
  - mem_we is decoded from state, so it is 0 during reset and no RAM write happens on any edge while rst is high.
  - Reset mid-sequence abandons the access with no response. A spanning store interrupted after WRITE_LO leaves the low word written; this is accepted.
- Accept: request taken on a clk edge with req_valid && req_ready. Address, funct3, wdata and store flag are registered at that edge.
- Decode at accept:
  - size = 1, 2 or 4 bytes; off = addr[1:0]; widx = addr>>2.
  - span = off+size>4.
  - widx+span >= MEM_WORDS, an illegal funct3, or span with ALLOW_MISALIGNED=0: go to RESP with err, no memory access.
- Little-endian byte lanes: byte k of the access maps to byte address addr+k.
- States and transitions:
  - IDLE: on accept go to RESP (error), to WRITE_LO (aligned SW, no read needed), or to READ_LO (everything else).
  - READ_LO: mem_a=widx; capture mem_rd into lo_q. Next state is WRITE_LO for stores, otherwise READ_HI if span, otherwise RESP.
  - WRITE_LO: mem_we=1; mem_wd = lo_q with the store bytes merged in (full wdata for aligned SW). Next is READ_HI if span, otherwise RESP.
  - READ_HI: mem_a=widx+1; capture hi_q. Next is WRITE_HI for stores, otherwise RESP.
  - WRITE_HI: mem_we=1 at widx+1, with the remaining store bytes merged into hi_q. Next is RESP.
  - RESP: resp_valid=1 for one cycle. resp_rdata is extracted from {hi_q,lo_q}: sign-extended for LB/LH, zero-extended for LBU/LHU. Next is IDLE.
- Latency, edges from accept to resp_valid:
  - Error: 1.
  - Aligned LW/LB/LH and aligned SW: 2.
  - Aligned SB/SH and spanning load: 3.
  - Spanning store: 5.
- Throughput: req_ready is low in RESP, so back-to-back requests have a minimum one-cycle bubble.
- Outside WRITE_x: mem_we=0 and mem_wd=0. mem_a holds its last value in IDLE/RESP.
- Wrap-around: widx+1 is computed modulo 2^ADDRESS_LENGTH but is always caught first by the MEM_WORDS range check.

Decomposition:
- lsu_pkg holds:
  - state enum (IDLE, READ_LO, WRITE_LO, READ_HI, WRITE_HI, RESP);
  - funct3 constants;
  - size decode function.
- One sub-module, lsu_align: combinational lane merge for stores and extract/extend for loads, over 64-bit {hi,lo} with off and size.

Test Plan:
RAM preload: word4=0x8899AABB, word5=0x11223344, word6=0x00000000.
- LB addr 0x11 -> resp_rdata 0xFFFFFFAA, resp_valid 2 edges after accept, mem_we never high. LBU at the same address -> 0x000000AA.
- SB addr 0x12 wdata 0x000000CC -> word4=0x88CCAABB. mem_we high for exactly 1 cycle, resp after 3 edges, resp_err=0.
- LW addr 0x13 -> resp_rdata 0x22334488 after 3 edges. With ALLOW_MISALIGNED=0 -> resp_err=1 after 1 edge, no memory access.
- SH addr 0x17 wdata 0x0000BEEF -> word5=0xEF223344, word6=0x000000BE. Two mem_we pulses, resp after 5 edges.
- funct3=011 load -> resp_err=1, resp_rdata=0, after 1 edge. Load at byte addr 0x9C40 (word 10000) -> resp_err=1.
- SB in flight with rst raised during WRITE_LO -> no RAM change, req_ready=1 and resp_valid=0 immediately. The next request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, RISC-V funct3 codes
// and the access-size decode.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_LO,
    ST_WRITE_LO,
    ST_READ_HI,
    ST_WRITE_HI,
    ST_RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size in bytes; 0 marks an illegal funct3 for the given direction.
  function automatic logic [2:0] f_size(input logic [2:0] f3, input logic store);
    logic [2:0] v_size;
    v_size = 3'd0;
    case (f3)
      F3_B:    v_size = 3'd1;
      F3_H:    v_size = 3'd2;
      F3_W:    v_size = 3'd4;
      F3_BU:   v_size = store ? 3'd0 : 3'd1;
      F3_HU:   v_size = store ? 3'd0 : 3'd2;
      default: v_size = 3'd0;
    endcase
    return v_size;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane merge for stores and extract/extend for loads over a
// little-endian {hi,lo} word pair.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [63:0] i_data,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_size,
  input  logic        i_sign,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_merged,
  output logic [31:0] o_rdata
);

  logic [63:0] w_shift;

  always_comb begin
    o_merged = i_data;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(i_size)) begin
        o_merged[(int'(i_off) + k) * 8 +: 8] = i_wdata[k * 8 +: 8];
      end
    end
  end

  always_comb begin
    w_shift = i_data >> {i_off, 3'b000};
    case (i_size)
      3'd1:    o_rdata = {{24{i_sign & w_shift[7]}}, w_shift[7:0]};
      3'd2:    o_rdata = {{16{i_sign & w_shift[15]}}, w_shift[15:0]};
      default: o_rdata = w_shift[31:0];
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: turns CPU byte/half/word accesses into word RAM accesses,
// running read-modify-write and two-word spanning sequences under an FSM.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDRESS_LENGTH   = 32,
  parameter int MEM_WORDS        = 10000,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_store,
  input  logic [2:0]                req_funct3,
  input  logic [ADDRESS_LENGTH-1:0] req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      resp_err,
  output logic [ADDRESS_LENGTH-1:0] mem_a,
  output logic                      mem_we,
  output logic [31:0]               mem_wd,
  input  logic [31:0]               mem_rd
);

  localparam int LP_EW = ADDRESS_LENGTH + 1;
  localparam logic [ADDRESS_LENGTH:0] LP_MEM_WORDS = LP_EW'(MEM_WORDS);

  state_t                    r_state;
  logic [ADDRESS_LENGTH-1:0] r_addr;
  logic [2:0]                r_f3;
  logic [31:0]               r_wdata;
  logic                      r_store;
  logic [31:0]               r_lo_q;
  logic [31:0]               r_hi_q;
  logic [ADDRESS_LENGTH-1:0] r_mem_a;
  logic                      r_resp_valid;
  logic [31:0]               r_resp_rdata;
  logic                      r_resp_err;

  logic [2:0]                w_req_size;
  logic [1:0]                w_req_off;
  logic [ADDRESS_LENGTH-1:0] w_req_widx;
  logic [3:0]                w_req_sum;
  logic                      w_req_span;
  logic [ADDRESS_LENGTH:0]   w_req_end;
  logic                      w_req_err;
  logic                      w_req_sw_aligned;

  logic [2:0]                w_size;
  logic [3:0]                w_sum;
  logic                      w_span;
  logic [ADDRESS_LENGTH-1:0] w_widx;
  logic [31:0]               w_lo;
  logic [31:0]               w_hi;
  logic [63:0]               w_merged;
  logic [31:0]               w_rdata;

  // Decode of the incoming request, used only on the accept edge.
  assign w_req_size       = f_size(req_funct3, req_store);
  assign w_req_off        = req_addr[1:0];
  assign w_req_widx       = req_addr >> 2;
  assign w_req_sum        = {2'b00, w_req_off} + {1'b0, w_req_size};
  assign w_req_span       = w_req_sum > 4'd4;
  assign w_req_end        = {1'b0, w_req_widx} + {{ADDRESS_LENGTH{1'b0}}, w_req_span};
  assign w_req_err        = (w_req_size == 3'd0) || (w_req_end >= LP_MEM_WORDS) ||
                            (w_req_span && !ALLOW_MISALIGNED);
  assign w_req_sw_aligned = req_store && (req_funct3 == F3_W) && (w_req_off == 2'b00);

  assign w_size = f_size(r_f3, r_store);
  assign w_sum  = {2'b00, r_addr[1:0]} + {1'b0, w_size};
  assign w_span = w_sum > 4'd4;
  assign w_widx = r_addr >> 2;

  // Forward the RAM word in the cycle it is read so the response can be
  // registered on the same edge that captures it.
  assign w_lo = (r_state == ST_READ_LO) ? mem_rd : r_lo_q;
  assign w_hi = (r_state == ST_READ_HI) ? mem_rd : r_hi_q;

  lsu_align u_align (
    .i_data   ({w_hi, w_lo}),
    .i_off    (r_addr[1:0]),
    .i_size   (w_size),
    .i_sign   (~r_f3[2]),
    .i_wdata  (r_wdata),
    .o_merged (w_merged),
    .o_rdata  (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_f3         <= '0;
      r_wdata      <= '0;
      r_store      <= 1'b0;
      r_lo_q       <= '0;
      r_hi_q       <= '0;
      r_mem_a      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_f3    <= req_funct3;
            r_wdata <= req_wdata;
            r_store <= req_store;
            if (w_req_err) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else begin
              r_mem_a <= w_req_widx;
              r_state <= w_req_sw_aligned ? ST_WRITE_LO : ST_READ_LO;
            end
          end
        end
        ST_READ_LO: begin
          r_lo_q <= mem_rd;
          if (r_store) begin
            r_state <= ST_WRITE_LO;
          end else if (w_span) begin
            r_state <= ST_READ_HI;
            r_mem_a <= w_widx + ADDRESS_LENGTH'(1);
          end else begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_rdata;
          end
        end
        ST_WRITE_LO: begin
          if (w_span) begin
            r_state <= ST_READ_HI;
            r_mem_a <= w_widx + ADDRESS_LENGTH'(1);
          end else begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
          end
        end
        ST_READ_HI: begin
          r_hi_q <= mem_rd;
          if (r_store) begin
            r_state <= ST_WRITE_HI;
          end else begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_rdata;
          end
        end
        ST_WRITE_HI: begin
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_a      = r_mem_a;
  assign mem_we     = (r_state == ST_WRITE_LO) || (r_state == ST_WRITE_HI);

  always_comb begin
    case (r_state)
      ST_WRITE_LO: mem_wd = w_merged[31:0];
      ST_WRITE_HI: mem_wd = w_merged[63:32];
      default:     mem_wd = '0;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a word RAM model, expected responses queued
// at issue and popped when the response pulse arrives.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid2;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, req_ready2;
  logic        resp_valid, resp_valid2;
  logic [31:0] resp_rdata, resp_rdata2;
  logic        resp_err, resp_err2;
  logic [31:0] mem_a, mem_a2;
  logic        mem_we, mem_we2;
  logic [31:0] mem_wd, mem_wd2;
  logic [31:0] mem_rd, mem_rd2;

  logic [31:0] ram [0:63];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwe;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return (a < 32'd64) ? ram[a[5:0]] : 32'hDEADBEEF;
  endfunction

  assign mem_rd  = rd_word(mem_a);
  assign mem_rd2 = rd_word(mem_a2);

  always @(posedge clk) begin
    if (mem_we && mem_a < 32'd64) ram[mem_a[5:0]] <= mem_wd;
  end

  lsu_ctrl #(.ADDRESS_LENGTH(32), .MEM_WORDS(10000), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  lsu_ctrl #(.ADDRESS_LENGTH(32), .MEM_WORDS(10000), .ALLOW_MISALIGNED(1'b0)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid2), .resp_rdata(resp_rdata2),
    .resp_err(resp_err2), .mem_a(mem_a2), .mem_we(mem_we2), .mem_wd(mem_wd2),
    .mem_rd(mem_rd2)
  );

  task automatic issue(input bit sel2, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    for (int i = 0; i < 10 && !(sel2 ? req_ready2 : req_ready); i++) @(negedge clk);
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    if (sel2) req_valid2 = 1'b1;
    else req_valid = 1'b1;
  endtask

  // Collects the response; lat stays 0 if none arrives within the budget.
  task automatic wait_resp(input bit sel2, output logic [31:0] rd, output logic er,
                           output int lat, output int nwe);
    lat = 0;
    nwe = 0;
    rd  = 'x;
    er  = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_valid2 = 1'b0;
      if (sel2 ? mem_we2 : mem_we) nwe++;
      if (sel2 ? resp_valid2 : resp_valid) begin
        lat = c;
        rd  = sel2 ? resp_rdata2 : resp_rdata;
        er  = sel2 ? resp_err2 : resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_valid2 = 1'b0; req_store = 1'b0;
    req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
    @(posedge clk);
    ram[4] <= 32'h8899AABB;
    ram[5] <= 32'h11223344;
    ram[6] <= 32'h00000000;
    @(negedge clk);
    n_checks++;
    if ({req_ready, resp_valid, resp_err, mem_we} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctl: got ready/valid/err/we=%b want 1000",
               {req_ready, resp_valid, resp_err, mem_we});
    end
    n_checks++;
    if ({resp_rdata, mem_wd} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: got rdata=%h wd=%h want 0", resp_rdata, mem_wd);
    end
    rst = 1'b0;
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [7]   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b010, 3'b000};
    logic [31:0] ad [7]   = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10, 32'h9C3C, 32'h13};
    logic [31:0] ex [7]   = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899,
                              32'h8899AABB, 32'hDEADBEEF, 32'hFFFFFF88};
    logic [31:0] rd;
    logic        er;
    int          lat, nwe;
    exp_t        e;
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, 1'b0, f3[i], ad[i], 32'h0);
      sb.push_back('{ex[i], 1'b0, 2, 0});
      wait_resp(1'b0, rd, er, lat, nwe);
      e = sb.pop_front();
      n_checks++;
      if (rd !== e.rdata || er !== e.err || lat != e.lat || nwe != e.nwe) begin
        n_fail++;
        $display("FAIL load_%0d: got rdata=%h err=%b lat=%0d we=%0d want rdata=%h err=%b lat=%0d we=%0d",
                 i, rd, er, lat, nwe, e.rdata, e.err, e.lat, e.nwe);
      end
    end
  endtask

  task automatic test_store_byte();
    logic [31:0] rd;
    logic        er;
    int          lat, nwe;
    exp_t        e;
    issue(1'b0, 1'b1, 3'b000, 32'h12, 32'h000000CC);
    sb.push_back('{32'h0, 1'b0, 3, 1});
    wait_resp(1'b0, rd, er, lat, nwe);
    e = sb.pop_front();
    n_checks++;
    if (rd !== e.rdata || er !== e.err || lat != e.lat || nwe != e.nwe) begin
      n_fail++;
      $display("FAIL sb: got rdata=%h err=%b lat=%0d we=%0d want rdata=%h err=%b lat=%0d we=%0d",
               rd, er, lat, nwe, e.rdata, e.err, e.lat, e.nwe);
    end
    n_checks++;
    if (ram[4] !== 32'h88CCAABB) begin
      n_fail++;
      $display("FAIL sb_ram: got word4=%h want 88ccaabb", ram[4]);
    end
  endtask

  task automatic test_misaligned();
    logic        st [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3 [3] = '{3'b010, 3'b001, 3'b001};
    logic [31:0] ad [3] = '{32'h13, 32'h17, 32'h17};
    logic [31:0] ex [3] = '{32'h22334488, 32'h0, 32'hFFFFBEEF};
    int          el [3] = '{3, 5, 3};
    int          ew [3] = '{0, 2, 0};
    logic [31:0] rd;
    logic        er;
    int          lat, nwe;
    exp_t        e;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, st[i], f3[i], ad[i], 32'h0000BEEF);
      sb.push_back('{ex[i], 1'b0, el[i], ew[i]});
      wait_resp(1'b0, rd, er, lat, nwe);
      e = sb.pop_front();
      n_checks++;
      if (rd !== e.rdata || er !== e.err || lat != e.lat || nwe != e.nwe) begin
        n_fail++;
        $display("FAIL span_%0d: got rdata=%h err=%b lat=%0d we=%0d want rdata=%h err=%b lat=%0d we=%0d",
                 i, rd, er, lat, nwe, e.rdata, e.err, e.lat, e.nwe);
      end
    end
    n_checks++;
    if ({ram[5], ram[6]} !== {32'hEF223344, 32'h000000BE}) begin
      n_fail++;
      $display("FAIL span_ram: got word5=%h word6=%h want ef223344 000000be", ram[5], ram[6]);
    end
  endtask

  task automatic test_errors();
    bit          s2 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        st [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0]  f3 [6] = '{3'b011, 3'b100, 3'b010, 3'b001, 3'b010, 3'b010};
    logic [31:0] ad [6] = '{32'h10, 32'h10, 32'h9C40, 32'h9C3F, 32'h13, 32'h10};
    logic [31:0] ex [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h88CCAABB};
    logic        ee [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int          el [6] = '{1, 1, 1, 1, 1, 2};
    logic [31:0] rd;
    logic        er;
    int          lat, nwe;
    exp_t        e;
    for (int i = 0; i < 6; i++) begin
      issue(s2[i], st[i], f3[i], ad[i], 32'hA5A5A5A5);
      sb.push_back('{ex[i], ee[i], el[i], 0});
      wait_resp(s2[i], rd, er, lat, nwe);
      e = sb.pop_front();
      n_checks++;
      if (rd !== e.rdata || er !== e.err || lat != e.lat || nwe != e.nwe) begin
        n_fail++;
        $display("FAIL err_%0d: got rdata=%h err=%b lat=%0d we=%0d want rdata=%h err=%b lat=%0d we=%0d",
                 i, rd, er, lat, nwe, e.rdata, e.err, e.lat, e.nwe);
      end
    end
    n_checks++;
    if (ram[4] !== 32'h88CCAABB) begin
      n_fail++;
      $display("FAIL err_ram: got word4=%h want 88ccaabb", ram[4]);
    end
  endtask

  task automatic test_back_to_back();
    logic        st [2] = '{1'b1, 1'b0};
    logic [31:0] ex [2] = '{32'h0, 32'h12345678};
    int          ew [2] = '{1, 0};
    logic [31:0] rd;
    logic        er;
    int          lat, nwe;
    exp_t        e;
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, st[i], 3'b010, 32'h18, 32'h12345678);
      sb.push_back('{ex[i], 1'b0, 2, ew[i]});
      wait_resp(1'b0, rd, er, lat, nwe);
      e = sb.pop_front();
      n_checks++;
      if (rd !== e.rdata || er !== e.err || lat != e.lat || nwe != e.nwe) begin
        n_fail++;
        $display("FAIL b2b_%0d: got rdata=%h err=%b lat=%0d we=%0d want rdata=%h err=%b lat=%0d we=%0d",
                 i, rd, er, lat, nwe, e.rdata, e.err, e.lat, e.nwe);
      end
      n_checks++;
      if (req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_bubble_%0d: got req_ready=%b during response want 0", i, req_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic        er;
    int          lat, nwe;
    exp_t        e;
    issue(1'b0, 1'b1, 3'b000, 32'h10, 32'h00000055);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_inwrite: got mem_we=%b want 1", mem_we);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, resp_valid, mem_we} !== 3'b100) begin
      n_fail++;
      $display("FAIL rst_mid_ctl: got ready/valid/we=%b want 100", {req_ready, resp_valid, mem_we});
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (ram[4] !== 32'h88CCAABB) begin
      n_fail++;
      $display("FAIL rst_mid_ram: got word4=%h want 88ccaabb", ram[4]);
    end
    issue(1'b0, 1'b0, 3'b000, 32'h10, 32'h0);
    sb.push_back('{32'hFFFFFFBB, 1'b0, 2, 0});
    wait_resp(1'b0, rd, er, lat, nwe);
    e = sb.pop_front();
    n_checks++;
    if (rd !== e.rdata || er !== e.err || lat != e.lat || nwe != e.nwe) begin
      n_fail++;
      $display("FAIL rst_mid_next: got rdata=%h err=%b lat=%0d we=%0d want rdata=%h err=%b lat=%0d we=%0d",
               rd, er, lat, nwe, e.rdata, e.err, e.lat, e.nwe);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_store_byte();
    test_misaligned();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
